axistream_pack: RTL and testbench
=================================

AXISTREAM_PACK -- requirements
Module: axistream_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one source word in bits.
REQ-002 Parameter NUM_PACK, default 4, legal range 2..16: number of source words packed into one destination word.
REQ-003 Parameter BIG_ENDIAN, default 1'b0: 0 places the first received word in bits [DATA_WIDTH-1:0]; 1 places it in the most significant slot.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 src_tvalid  input  1  source word valid.
REQ-007 src_tready  output  1  block accepts the source word.
REQ-008 src_tdata  input  DATA_WIDTH  source word.
REQ-009 src_tlast  input  1  last word of packet.
REQ-010 dest_tvalid  output  1  packed word valid.
REQ-011 dest_tready  input  1  downstream accepts the packed word.
REQ-012 dest_tdata  output  DATA_WIDTH*NUM_PACK  packed word.
REQ-013 dest_tkeep  output  NUM_PACK  bit i set means slot i holds a received word.
REQ-014 dest_tlast  output  1  packed word ends a packet.

Function
REQ-015 A transfer SHALL occur on a side only in a cycle where its tvalid and tready are both high.
REQ-016 The block SHALL hold an accumulator (slot data, slot count 0..NUM_PACK-1, keep mask) and one registered output stage.
REQ-017 Each accepted source word SHALL be written to slot cnt, or slot NUM_PACK-1-cnt when BIG_ENDIAN=1, and its keep bit set.
REQ-018 The block SHALL flush when an accepted word fills slot count NUM_PACK-1 or carries src_tlast=1: the accumulator plus that word load the output stage, dest_tlast=src_tlast, and the accumulator clears to count 0 with keep all zero.
REQ-019 Slots not written before an early tlast SHALL read 0 in dest_tdata, and their dest_tkeep bits SHALL be 0.
REQ-020 Flush latency SHALL be one cycle: dest_tvalid rises on the edge that accepts the flushing word.
REQ-021 src_tready SHALL equal rst_n AND (NOT dest_tvalid OR dest_tready), combinationally.
REQ-022 With src_tvalid and dest_tready held high, the block SHALL sustain one source word per cycle with no bubbles.
REQ-023 dest_tdata, dest_tkeep and dest_tlast SHALL remain stable while dest_tvalid=1 and dest_tready=0.
REQ-024 dest_tvalid SHALL clear after a destination transfer unless a flush occurs in the same cycle, in which case the output stage reloads with the new word.
REQ-025 A single-word packet (tlast on the first word) SHALL produce one output with exactly one keep bit set.
REQ-026 The slot counter SHALL wrap from NUM_PACK-1 to 0 and never exceed NUM_PACK-1.

Reset
REQ-027 While rst_n=0, the block SHALL hold dest_tvalid=0, src_tready=0, accumulator count 0, keep 0, and dest_tdata, dest_tkeep and dest_tlast at 0.
REQ-028 Reset mid-packet SHALL discard the partial accumulator and any pending output word; no partial word SHALL be emitted afterwards.
REQ-029 Reset SHALL deassert synchronously to clk; the first transfer SHALL be possible on the first edge after deassertion.

Structure
REQ-030 No shared package SHALL be used; the counter width, $clog2(NUM_PACK), SHALL be a local parameter.
REQ-031 The block SHALL be a single module with no sub-modules; slot placement SHALL use a generate loop.
REQ-032 The output of axistream_pack with a given parameter set SHALL feed axistream_unpack with the same parameters and reproduce the input stream, including tlast, for packets whose length is a multiple of NUM_PACK.

Verification (DATA_WIDTH=8, NUM_PACK=4)
REQ-033 Full packet: send 0x11,0x22,0x33,0x44 with tlast on 0x44, BIG_ENDIAN=0 -> one output 0x44332211, keep 4'b1111, tlast=1; with BIG_ENDIAN=1 -> 0x11223344.
REQ-034 Early tlast: send 0xAA,0xBB with tlast on 0xBB -> 0x0000BBAA, keep 4'b0011, tlast=1.
REQ-035 Backpressure: hold dest_tready=0 for 5 cycles while 8 words are offered -> src_tready drops once the output is full, the output holds stable, and both packed words arrive in order once dest_tready=1.
REQ-036 Streaming: offer 32 continuous words with dest_tready=1 -> 8 outputs, one every 4 cycles, with src_tready never low.
REQ-037 Reset mid-packet: accept 0x01,0x02, pulse rst_n low, then send 0x05..0x08 with tlast -> only 0x08070605 is emitted.
REQ-038 Loopback: pack feeding unpack, with random valid/ready stalls over 1000 words -> output stream identical to the input stream.

Source files
------------

// File: rtl/axistream_pack.sv
// axistream_pack: gathers NUM_PACK narrow AXI-Stream words into one wide word.
// A word that fills the last slot, or carries tlast, flushes the accumulator
// together with itself into a single registered output stage.
module axistream_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           src_tvalid,
    output logic                           src_tready,
    input  logic [DATA_WIDTH-1:0]          src_tdata,
    input  logic                           src_tlast,
    output logic                           dest_tvalid,
    input  logic                           dest_tready,
    output logic [DATA_WIDTH*NUM_PACK-1:0] dest_tdata,
    output logic [NUM_PACK-1:0]            dest_tkeep,
    output logic                           dest_tlast
);

    localparam int            CW        = $clog2(NUM_PACK);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_PACK - 1);

    logic [CW-1:0]                       cnt;
    logic [NUM_PACK-1:0][DATA_WIDTH-1:0] acc_data;
    logic [NUM_PACK-1:0][DATA_WIDTH-1:0] acc_data_nxt;
    logic [NUM_PACK-1:0][DATA_WIDTH-1:0] out_data;
    logic [NUM_PACK-1:0]                 acc_keep;
    logic [NUM_PACK-1:0]                 acc_keep_nxt;
    logic [NUM_PACK-1:0]                 out_keep;
    logic                                out_valid;
    logic                                out_last;
    logic                                accept;
    logic                                flush;

    // The output stage is the only storage that can back up, so the source
    // may move whenever it is empty or being drained this cycle.
    assign src_tready = rst_n & (~out_valid | dest_tready);
    assign accept     = src_tvalid & src_tready;
    assign flush      = accept & (src_tlast | (cnt == LAST_SLOT));

    // Each slot knows which arrival order it takes; the merged view
    // (accumulator plus the word arriving now) feeds both the accumulator
    // and, on a flush, the output stage.
    for (genvar s = 0; s < NUM_PACK; s++) begin : g_slot
        localparam logic [CW-1:0] ORDER = CW'(BIG_ENDIAN ? (NUM_PACK - 1 - s) : s);
        logic wr;
        assign wr              = accept && (cnt == ORDER);
        assign acc_data_nxt[s] = wr ? src_tdata : acc_data[s];
        assign acc_keep_nxt[s] = wr | acc_keep[s];
    end

    // Accumulator: collect words until a flush, then restart empty so that
    // unwritten slots of a short packet read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (flush) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            cnt      <= cnt + 1'b1;
            acc_data <= acc_data_nxt;
            acc_keep <= acc_keep_nxt;
        end
    end

    // Output stage: load on flush (also when draining the previous word in
    // the same cycle), clear valid after a transfer, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b1;
            out_data  <= acc_data_nxt;
            out_keep  <= acc_keep_nxt;
            out_last  <= src_tlast;
        end else if (dest_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign dest_tvalid = out_valid;
    assign dest_tdata  = out_data;
    assign dest_tkeep  = out_keep;
    assign dest_tlast  = out_last;

endmodule

// File: tb/tb_axistream_pack.sv
// Bench for axistream_pack: little- and big-endian instances share one source
// stream and one dest_tready; a monitor models the packing and scoreboards
// every packed word leaving both instances.
module tb_axistream_pack;

    typedef struct packed {
        logic [31:0] le;
        logic [31:0] be;
        logic [3:0]  kle;
        logic [3:0]  kbe;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_tvalid;
    logic [7:0]  src_tdata;
    logic        src_tlast;
    logic        dest_tready;
    logic        tr_le, tr_be;
    logic        dv_le, dv_be;
    logic [31:0] dd_le, dd_be;
    logic [3:0]  dk_le, dk_be;
    logic        dl_le, dl_be;

    int checks = 0;
    int errors = 0;

    exp_t        sb[$];
    logic [7:0]  m_le[4];
    logic [7:0]  m_be[4];
    logic [3:0]  m_kle, m_kbe;
    int          m_cnt;
    int          rx_count = 0;
    logic [31:0] rx_le, rx_be;
    logic [3:0]  rx_kle, rx_kbe;
    logic        rx_last;
    int          cyc = 0;
    logic        stall = 1'b0;
    logic [31:0] h_le, h_be;
    logic [3:0]  h_k;
    logic        h_l;
    logic        low_seen = 1'b0;
    logic        meas = 1'b0;
    logic        have_prev = 1'b0;
    int          prev_cyc;
    logic        rnd_done;

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(tr_le), .src_tdata(src_tdata), .src_tlast(src_tlast),
        .dest_tvalid(dv_le), .dest_tready(dest_tready), .dest_tdata(dd_le), .dest_tkeep(dk_le),
        .dest_tlast(dl_le)
    );

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(tr_be), .src_tdata(src_tdata), .src_tlast(src_tlast),
        .dest_tvalid(dv_be), .dest_tready(dest_tready), .dest_tdata(dd_be), .dest_tkeep(dk_be),
        .dest_tlast(dl_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_le[i] = '0;
            m_be[i] = '0;
        end
        m_kle = '0;
        m_kbe = '0;
        m_cnt = 0;
    endtask

    // Monitor: mid-cycle view of everything that transfers on the next edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("rst_tvalid", {63'd0, dv_le}, 64'd0);
            chk("rst_tready", {63'd0, tr_le}, 64'd0);
            chk("rst_tdata", {32'd0, dd_le}, 64'd0);
            chk("rst_tkeep", {60'd0, dk_le}, 64'd0);
            chk("rst_tlast", {63'd0, dl_le}, 64'd0);
            chk("rst_be_tvalid", {63'd0, dv_be}, 64'd0);
            model_clear();
            sb.delete();
            stall = 1'b0;
        end else begin
            chk("tready_rule", {63'd0, tr_le}, {63'd0, (!dv_le || dest_tready)});
            chk("be_tready", {63'd0, tr_be}, {63'd0, tr_le});
            chk("be_tvalid", {63'd0, dv_be}, {63'd0, dv_le});
            if (stall) begin
                chk("hold_valid", {63'd0, dv_le}, 64'd1);
                chk("hold_data_le", {32'd0, dd_le}, {32'd0, h_le});
                chk("hold_data_be", {32'd0, dd_be}, {32'd0, h_be});
                chk("hold_keep", {60'd0, dk_le}, {60'd0, h_k});
                chk("hold_last", {63'd0, dl_le}, {63'd0, h_l});
            end
            if (src_tvalid && !tr_le) low_seen = 1'b1;
            if (dv_le && dest_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out observed=%0h expected=none", dd_le);
                end else begin
                    e = sb.pop_front();
                    chk("out_data_le", {32'd0, dd_le}, {32'd0, e.le});
                    chk("out_data_be", {32'd0, dd_be}, {32'd0, e.be});
                    chk("out_keep_le", {60'd0, dk_le}, {60'd0, e.kle});
                    chk("out_keep_be", {60'd0, dk_be}, {60'd0, e.kbe});
                    chk("out_last", {63'd0, dl_le}, {63'd0, e.last});
                end
                rx_count++;
                rx_le   = dd_le;
                rx_be   = dd_be;
                rx_kle  = dk_le;
                rx_kbe  = dk_be;
                rx_last = dl_le;
                if (meas && have_prev) chk("stream_gap", 64'(cyc - prev_cyc), 64'd4);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
            stall = dv_le && !dest_tready;
            h_le  = dd_le;
            h_be  = dd_be;
            h_k   = dk_le;
            h_l   = dl_le;
            if (src_tvalid && tr_le) begin
                m_le[m_cnt]     = src_tdata;
                m_be[3 - m_cnt] = src_tdata;
                m_kle[m_cnt]     = 1'b1;
                m_kbe[3 - m_cnt] = 1'b1;
                if (m_cnt == 3 || src_tlast) begin
                    e.le   = {m_le[3], m_le[2], m_le[1], m_le[0]};
                    e.be   = {m_be[3], m_be[2], m_be[1], m_be[0]};
                    e.kle  = m_kle;
                    e.kbe  = m_kbe;
                    e.last = src_tlast;
                    sb.push_back(e);
                    model_clear();
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Offer one word and hold it until accepted; n counts cycles spent.
    task automatic send(input logic [7:0] d, input logic l, output int n);
        logic ok;
        src_tvalid = 1'b1;
        src_tdata  = d;
        src_tlast  = l;
        n = 0;
        forever begin
            @(negedge clk);
            ok = tr_le;
            @(posedge clk);
            #1;
            n++;
            if (ok) break;
            if (n >= 200) begin
                checks++;
                errors++;
                $error("FAIL send_timeout observed=%0d cycles expected=accept", n);
                break;
            end
        end
    endtask

    task automatic idle();
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        int b = 0;
        while (rx_count < target && b < 100) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk("rx_count", 64'(rx_count), 64'(target));
    endtask

    initial begin
        int n;
        int base;
        rst_n       = 1'b0;
        src_tvalid  = 1'b0;
        src_tdata   = '0;
        src_tlast   = 1'b0;
        dest_tready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full packet
        base = rx_count;
        send(8'h11, 1'b0, n);
        send(8'h22, 1'b0, n);
        send(8'h33, 1'b0, n);
        send(8'h44, 1'b1, n);
        idle();
        wait_rx(base + 1);
        chk("full_le", {32'd0, rx_le}, 64'h4433_2211);
        chk("full_be", {32'd0, rx_be}, 64'h1122_3344);
        chk("full_keep", {60'd0, rx_kle}, 64'hf);
        chk("full_last", {63'd0, rx_last}, 64'd1);

        // Early tlast
        base = rx_count;
        send(8'hAA, 1'b0, n);
        send(8'hBB, 1'b1, n);
        idle();
        wait_rx(base + 1);
        chk("early_le", {32'd0, rx_le}, 64'h0000_BBAA);
        chk("early_be", {32'd0, rx_be}, 64'hAABB_0000);
        chk("early_keep_le", {60'd0, rx_kle}, 64'h3);
        chk("early_keep_be", {60'd0, rx_kbe}, 64'hc);
        chk("early_last", {63'd0, rx_last}, 64'd1);

        // Single-word packet
        base = rx_count;
        send(8'h5A, 1'b1, n);
        idle();
        wait_rx(base + 1);
        chk("single_le", {32'd0, rx_le}, 64'h0000_005A);
        chk("single_be", {32'd0, rx_be}, 64'h5A00_0000);
        chk("single_keep_le", {60'd0, rx_kle}, 64'h1);
        chk("single_keep_be", {60'd0, rx_kbe}, 64'h8);

        // Backpressure: output blocked for 5 cycles while 8 words are offered
        base = rx_count;
        low_seen = 1'b0;
        dest_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, n);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                dest_tready = 1'b1;
            end
        join
        wait_rx(base + 2);
        chk("bp_tready_dropped", {63'd0, low_seen}, 64'd1);
        chk("bp_second", {32'd0, rx_le}, 64'h0807_0605);
        chk("bp_last", {63'd0, rx_last}, 64'd0);

        // Streaming: 32 back-to-back words, one output every 4 cycles
        base = rx_count;
        low_seen  = 1'b0;
        have_prev = 1'b0;
        meas      = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(8'(8'h80 + i), (i == 31), n);
            chk("stream_accept_cycles", 64'(n), 64'd1);
        end
        idle();
        wait_rx(base + 8);
        meas = 1'b0;
        chk("stream_no_stall", {63'd0, low_seen}, 64'd0);
        chk("stream_last", {32'd0, rx_le}, 64'h9F9E_9D9C);

        // Reset mid-packet discards the partial word
        send(8'h01, 1'b0, n);
        send(8'h02, 1'b0, n);
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = rx_count;
        send(8'h05, 1'b0, n);
        chk("first_after_reset", 64'(n), 64'd1);
        send(8'h06, 1'b0, n);
        send(8'h07, 1'b0, n);
        send(8'h08, 1'b1, n);
        idle();
        wait_rx(base + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("reset_only_one", 64'(rx_count), 64'(base + 1));
        chk("reset_word", {32'd0, rx_le}, 64'h0807_0605);
        chk("reset_keep", {60'd0, rx_kle}, 64'hf);

        // Random stalls on both sides over 1000 words
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    send(8'($urandom), ($urandom_range(0, 5) == 0), n);
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    dest_tready = ($urandom_range(0, 3) != 0);
                end
                dest_tready = 1'b1;
            end
        join
        // Flush any trailing partial packet, then drain
        send(8'hEE, 1'b1, n);
        idle();
        for (int b = 0; b < 100 && sb.size() != 0; b++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", {63'd0, dv_le}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
